// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC coefficient-statistics path.
package cavlc_pkg;

  typedef enum logic [0:0] {
    S_ACC  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  localparam int BLK_LEN_CDC  = 4;
  localparam int BLK_LEN_AC   = 15;
  localparam int BLK_LEN_LUMA = 16;
  localparam int MAX_COEF_DEF = 16;

  function automatic int cnt_width(input int max_coef);
    return $clog2(max_coef + 1);
  endfunction

  localparam int CNT_W = cnt_width(MAX_COEF_DEF);

endpackage

// File: rtl/cavlc_coef_class.sv
// Combinational coefficient classifier: zero, +/-1, or any other nonzero value.
module cavlc_coef_class #(
  parameter int COEF_W = 15
) (
  input  logic [COEF_W-1:0] coef,
  output logic              is_zero,
  output logic              is_one,
  output logic              is_large
);

  localparam logic [COEF_W-1:0] PLUS_ONE = {{(COEF_W-1){1'b0}}, 1'b1};

  // classify one coefficient; all-ones is -1 in two's complement
  always_comb begin
    is_zero  = (coef == {COEF_W{1'b0}});
    is_one   = (coef == PLUS_ONE) || (coef == {COEF_W{1'b1}});
    is_large = !is_zero && !is_one;
  end

endmodule

// File: rtl/cavlc_zero_scan.sv
// Streaming TotalCoeff / TotalZeros / TrailingOnes unit with handshaked result register.
// Build option: define CAVLC_T1_EN to build the trailing-ones tracker.
module cavlc_zero_scan
  import cavlc_pkg::*;
#(
  parameter  int COEF_W   = 15,
  parameter  int MAX_COEF = 16,
  localparam int CW       = cnt_width(MAX_COEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     blk_len,
  input  logic [COEF_W-1:0] in_coef,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     total_coeff,
  output logic [CW-1:0]     total_zeros,
  output logic [1:0]        trailing_ones,
  output logic              len_err
);

  localparam logic [CW-1:0] MAX_LEN = CW'(MAX_COEF);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r, state_nxt;
  logic [CW-1:0] beat_r, beat_nxt;
  logic [CW-1:0] zcnt_r, zcnt_nxt;
  logic [CW-1:0] tc_r, tc_nxt;
  logic [CW-1:0] tz_r, tz_nxt;
  logic [CW-1:0] len_r, len_nxt;
  logic [CW-1:0] len_in_s, len_cur_s;
  logic          is_zero_s, is_one_s, is_large_s, nonzero_s;
  logic          accept_s, at_len_s, close_s;
  logic [CW-1:0] total_coeff_r, total_zeros_r;
  logic          len_err_r;

  cavlc_coef_class #(.COEF_W(COEF_W)) u_class (
    .coef     (in_coef),
    .is_zero  (is_zero_s),
    .is_one   (is_one_s),
    .is_large (is_large_s)
  );

  assign in_ready    = (state_r == S_ACC) && !rst;
  assign out_valid   = (state_r == S_DONE);
  assign accept_s    = in_valid && in_ready;
  assign nonzero_s   = is_one_s || is_large_s;
  assign total_coeff = total_coeff_r;
  assign total_zeros = total_zeros_r;
  assign len_err     = len_err_r;

  // out-of-range lengths fall back to the longest block; latched length applies after beat 1
  assign len_in_s  = ((blk_len == {CW{1'b0}}) || (blk_len > MAX_LEN)) ? MAX_LEN : blk_len;
  assign len_cur_s = (beat_r == {CW{1'b0}}) ? len_in_s : len_r;

  // next-state and accumulator update
  always_comb begin
    state_nxt = state_r;
    beat_nxt  = beat_r;
    zcnt_nxt  = zcnt_r;
    tc_nxt    = tc_r;
    tz_nxt    = tz_r;
    len_nxt   = len_r;
    at_len_s  = 1'b0;
    close_s   = 1'b0;
    case (state_r)
      S_ACC: begin
        if (accept_s) begin
          beat_nxt = beat_r + CNT_ONE;
          len_nxt  = len_cur_s;
          at_len_s = (beat_nxt == len_cur_s);
          close_s  = in_last || at_len_s;
          if (is_zero_s) begin
            zcnt_nxt = zcnt_r + CNT_ONE;
          end else begin
            zcnt_nxt = zcnt_r;
          end
          if (nonzero_s) begin
            tc_nxt = tc_r + CNT_ONE;
            tz_nxt = zcnt_r;
          end else begin
            tc_nxt = tc_r;
            tz_nxt = tz_r;
          end
          if (close_s) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ACC;
          end
        end else begin
          state_nxt = S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_ACC;
          beat_nxt  = {CW{1'b0}};
          zcnt_nxt  = {CW{1'b0}};
          tc_nxt    = {CW{1'b0}};
          tz_nxt    = {CW{1'b0}};
          len_nxt   = {CW{1'b0}};
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_ACC;
      end
    endcase
  end

  // state, accumulators and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_ACC;
      beat_r        <= {CW{1'b0}};
      zcnt_r        <= {CW{1'b0}};
      tc_r          <= {CW{1'b0}};
      tz_r          <= {CW{1'b0}};
      len_r         <= {CW{1'b0}};
      total_coeff_r <= {CW{1'b0}};
      total_zeros_r <= {CW{1'b0}};
      len_err_r     <= 1'b0;
    end else begin
      state_r <= state_nxt;
      beat_r  <= beat_nxt;
      zcnt_r  <= zcnt_nxt;
      tc_r    <= tc_nxt;
      tz_r    <= tz_nxt;
      len_r   <= len_nxt;
      if (close_s) begin
        total_coeff_r <= tc_nxt;
        total_zeros_r <= tz_nxt;
        len_err_r     <= in_last ^ at_len_s;
      end
    end
  end

`ifdef CAVLC_T1_EN
  logic [1:0] t1_r, t1_nxt, trailing_ones_r;

  // running count of consecutive +/-1 values among the nonzeros, saturating at 3
  always_comb begin
    t1_nxt = t1_r;
    if (state_r == S_DONE) begin
      if (out_ready) begin
        t1_nxt = 2'd0;
      end else begin
        t1_nxt = t1_r;
      end
    end else if (accept_s && nonzero_s) begin
      if (is_one_s) begin
        t1_nxt = (t1_r == 2'd3) ? 2'd3 : t1_r + 2'd1;
      end else begin
        t1_nxt = 2'd0;
      end
    end else begin
      t1_nxt = t1_r;
    end
  end

  // trailing-ones accumulator and its result register
  always_ff @(posedge clk) begin
    if (rst) begin
      t1_r            <= 2'd0;
      trailing_ones_r <= 2'd0;
    end else begin
      t1_r <= t1_nxt;
      if (close_s) begin
        trailing_ones_r <= t1_nxt;
      end
    end
  end

  assign trailing_ones = trailing_ones_r;
`else
  assign trailing_ones = 2'd0;
`endif

endmodule

// File: tb/tb_cavlc_zero_scan.sv
// Scoreboard bench for cavlc_zero_scan: directed blocks followed by randomized blocks.
module tb_cavlc_zero_scan;

  localparam int COEF_W = 15;
  localparam int CW     = 5;

  typedef struct {
    int tc;
    int tz;
    int t1;
    int err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CW-1:0]     blk_len = '0;
  logic [COEF_W-1:0] in_coef = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     total_coeff;
  logic [CW-1:0]     total_zeros;
  logic [1:0]        trailing_ones;
  logic              len_err;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exp_t              exp_q[$];
  int                close_q[$];
  logic [COEF_W-1:0] cq[$];

  cavlc_zero_scan dut (
    .clk           (clk),
    .rst           (rst),
    .blk_len       (blk_len),
    .in_coef       (in_coef),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .total_coeff   (total_coeff),
    .total_zeros   (total_zeros),
    .trailing_ones (trailing_ones),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: statistics of the first n coefficients of cq, straight from the block rules.
  task automatic model(input int len_in, input int last_pos, output int n, output exp_t e);
    int L;
    int last_nz;
    int nz_vals[$];
    logic [COEF_W-1:0] v;
    L = (len_in == 0 || len_in > 16) ? 16 : len_in;
    n = (last_pos >= 1 && last_pos <= L) ? last_pos : L;
    e.err = ((last_pos >= 1 && last_pos <= L) ? 1 : 0) ^ ((n == L) ? 1 : 0);
    e.tc = 0;
    last_nz = -1;
    for (int i = 0; i < n; i++) begin
      v = cq[i];
      if (v != 0) begin
        e.tc++;
        last_nz = i;
        nz_vals.push_back((v == 15'd1 || v == 15'h7fff) ? 1 : 0);
      end
    end
    e.tz = 0;
    for (int i = 0; i < last_nz; i++) begin
      v = cq[i];
      if (v == 0) e.tz++;
    end
    e.t1 = 0;
    for (int i = nz_vals.size() - 1; i >= 0; i--) begin
      if (nz_vals[i] == 0) break;
      e.t1++;
    end
    if (e.t1 > 3) e.t1 = 3;
`ifndef CAVLC_T1_EN
    e.t1 = 0;
`endif
  endtask

  // Drive one block from cq; abort_at > 0 sends that many beats and then resets the unit.
  task automatic run_block(input int len_in, input int last_pos, input int abort_at, input bit gaps);
    int n;
    int nsend;
    int guard;
    exp_t e;
    model(len_in, last_pos, n, e);
    nsend = (abort_at > 0) ? abort_at : n;
    if (abort_at == 0) exp_q.push_back(e);
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk);
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_coef  = cq[i];
      in_last  = (i + 1 == last_pos);
      blk_len  = CW'(len_in);
      guard = 0;
      while (!in_ready) begin
        @(negedge clk);
        guard++;
        if (guard > 60) begin
          $display("FAIL in_ready_timeout: got 0, expected 1 within 60 cycles");
          $fatal(1, "in_ready never returned");
        end
      end
      if (i == n - 1 && abort_at == 0) close_q.push_back(cyc + 1);
    end
    if (abort_at > 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_total_coeff", total_coeff, 0);
      chk("abort_total_zeros", total_zeros, 0);
    end
  endtask

  task automatic rand_coefs(input int cnt);
    int r;
    cq.delete();
    for (int i = 0; i < cnt; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       cq.push_back(15'd0);
      else if (r < 7)  cq.push_back(15'd1);
      else if (r == 7) cq.push_back(15'h7fff);
      else if (r == 8) cq.push_back(15'($urandom_range(2, 9)));
      else             cq.push_back(15'($urandom));
    end
  endtask

  // Monitor: pop one expected result per out_valid episode, recheck it every held cycle.
  initial begin
    exp_t cur;
    bit   held = 0;
    bit   have = 0;
    int   hold = 0;
    forever begin
      @(negedge clk);
      #1;
      chk("in_ready", in_ready, (!out_valid && !rst) ? 1 : 0);
      if (out_valid) begin
        if (!held) begin
          held = 1;
          hold = $urandom_range(0, 3);
          if (exp_q.size() == 0 || close_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
            have = 0;
          end else begin
            cur  = exp_q.pop_front();
            have = 1;
            chk("latency", cyc, close_q.pop_front());
          end
        end
        if (have) begin
          chk("total_coeff", total_coeff, cur.tc);
          chk("total_zeros", total_zeros, cur.tz);
          chk("trailing_ones", trailing_ones, cur.t1);
          chk("len_err", len_err, cur.err);
        end
        out_ready = (hold == 0);
        if (hold > 0) hold--;
        if (out_ready) held = 0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int guard;
    int lens[12] = '{4, 15, 16, 16, 15, 4, 1, 2, 0, 20, 31, 8};
    int len_in;
    int L;
    int lp;
    int r;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_total_coeff", total_coeff, 0);
    chk("rst_total_zeros", total_zeros, 0);
    chk("rst_trailing_ones", trailing_ones, 0);
    chk("rst_len_err", len_err, 0);
    rst = 1'b0;

    // luma mixed block
    cq = {15'd0, 15'd3, 15'd0, 15'd1, 15'd0, 15'd0, 15'h7fff, 15'd1,
          15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};
    run_block(16, 16, 0, 0);
    // saturation, then all-zero
    cq = {15'd1, 15'd1, 15'd1, 15'd1, 15'd0, 15'd0, 15'd0, 15'd0,
          15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};
    run_block(16, 16, 0, 0);
    rand_coefs(0);
    for (int i = 0; i < 16; i++) cq.push_back(15'd0);
    run_block(16, 16, 0, 0);
    // chroma DC back to back
    cq = {15'd0, 15'd0, 15'd0, 15'd5};
    run_block(4, 4, 0, 0);
    cq = {15'h7fff, 15'd0, 15'd2, 15'd1};
    run_block(4, 4, 0, 0);
    // length mismatches
    cq = {15'd0, 15'd7, 15'd1, 15'd0, 15'd0, 15'd1, 15'd0, 15'd0, 15'd0, 15'd1};
    run_block(16, 10, 0, 0);
    cq = {15'd1, 15'd0, 15'd0, 15'd0};
    run_block(4, 0, 0, 0);
    // reset at beat 7, then a clean block
    rand_coefs(16);
    run_block(16, 16, 7, 0);
    cq = {15'd0, 15'd0, 15'd1, 15'd9, 15'd0, 15'h7fff, 15'd0, 15'd0,
          15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};
    run_block(16, 16, 0, 0);

    // randomized blocks
    for (int b = 0; b < 150; b++) begin
      len_in = lens[$urandom_range(0, 11)];
      L = (len_in == 0 || len_in > 16) ? 16 : len_in;
      r = $urandom_range(0, 19);
      if (r < 14)                 lp = L;
      else if (r < 17 && L > 1)   lp = $urandom_range(1, L - 1);
      else                        lp = 0;
      rand_coefs(L);
      if ($urandom_range(0, 29) == 0 && L > 2) run_block(len_in, lp, $urandom_range(1, L - 2), 1);
      else                                     run_block(len_in, lp, 0, 1);
    end

    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
